// File: rtl/mux_scan_sequencer.sv
// Round-robin scan controller for a 4:1 bit mux: dwells DWELL cycles per channel, assembles a 4-bit frame, valid/ready out.
// Optional build macro SCAN_MASK_EN adds a per-scan channel enable mask (ch_mask).
module mux_scan_sequencer #(
    parameter int DWELL = 2,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       continuous,
    input  logic       mux_out,
`ifdef SCAN_MASK_EN
    input  logic [3:0] ch_mask,
`endif
    input  logic       frame_ready,
    output logic [1:0] sel,
    output logic [3:0] frame,
    output logic       frame_valid,
    output logic       busy
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DWELL - 1);

    state_t           r_state;
    state_t           w_next;
    logic [1:0]       r_sel;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_shadow;
    logic [3:0]       r_frame;
    logic             r_valid;

    logic [3:0] w_mask;
    logic [3:0] w_start_mask;
    logic       w_start_empty;
    logic       w_start_scan;
    logic       w_dwell_done;
    logic [2:0] w_first;
    logic [2:0] w_next_ch;
    logic [3:0] w_sample;

    // Lowest enabled channel at or above lo; bit 2 flags that one was found.
    function automatic logic [2:0] find_from(input logic [3:0] m, input int lo);
        logic [2:0] res;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (m[i] && i >= lo) res = {1'b1, 2'(i)};
        end
        return res;
    endfunction

`ifdef SCAN_MASK_EN
    logic [3:0] r_mask;
    assign w_mask       = r_mask;
    assign w_start_mask = ch_mask;
`else
    assign w_mask       = 4'hF;
    assign w_start_mask = 4'hF;
`endif

    assign w_start_empty = (w_start_mask == 4'h0);
    assign w_first       = find_from(w_start_mask, 0);
    assign w_next_ch     = find_from(w_mask, int'(r_sel) + 1);
    assign w_dwell_done  = (r_cnt == LP_LAST);
    assign w_start_scan  = (r_state == S_IDLE && start) ||
                           (r_state == S_DONE && frame_ready && continuous);

    always_comb begin
        w_sample        = r_shadow;
        w_sample[r_sel] = mux_out;
    end

    // NOTE: async reset on every flop, including the shadow register, so a reset mid-scan discards any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_next = w_start_empty ? S_DONE : S_SCAN;
            S_SCAN: if (w_dwell_done && !w_next_ch[2]) w_next = S_DONE;
            S_DONE: if (frame_ready) begin
                if (continuous) w_next = w_start_empty ? S_DONE : S_SCAN;
                else            w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel    <= 2'd0;
            r_cnt    <= '0;
            r_shadow <= 4'h0;
            r_frame  <= 4'h0;
            r_valid  <= 1'b0;
`ifdef SCAN_MASK_EN
            r_mask   <= 4'h0;
`endif
        end else if (w_start_scan) begin
            r_sel    <= w_first[1:0];
            r_cnt    <= '0;
            r_shadow <= 4'h0;
            r_valid  <= w_start_empty;
            if (w_start_empty) r_frame <= 4'h0;
`ifdef SCAN_MASK_EN
            r_mask   <= ch_mask;
`endif
        end else begin
            case (r_state)
                S_SCAN: begin
                    if (w_dwell_done) begin
                        r_cnt    <= '0;
                        r_shadow <= w_sample;
                        if (w_next_ch[2]) begin
                            r_sel <= w_next_ch[1:0];
                        end else begin
                            r_frame <= w_sample;
                            r_valid <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: if (frame_ready) begin
                    r_valid <= 1'b0;
                    r_sel   <= 2'd0;
                end
                default: r_sel <= 2'd0;
            endcase
        end
    end

    always_comb begin
        busy        = (r_state != S_IDLE);
        sel         = r_sel;
        frame       = r_frame;
        frame_valid = r_valid;
    end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Self-checking bench for mux_scan_sequencer (default build, DWELL=2): vector table plus multi-cycle corner sequences.
module tb_mux_scan_sequencer;

    localparam int DWELL = 2;
    localparam int LAT   = 4 * DWELL;

    typedef struct {
        logic [3:0] ins;
        logic [3:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       continuous = 1'b0;
    logic       frame_ready = 1'b1;
    logic [3:0] r_inputs = 4'h0;
    logic       w_mux_out;
    logic [1:0] sel;
    logic [3:0] frame;
    logic       frame_valid;
    logic       busy;

    int         n_tests = 0;
    int         n_fail = 0;
    logic [3:0] exp_q[$];
    logic       seen_valid = 1'b0;

    // Behavioural 4:1 mux fed by the bench's channel inputs.
    assign w_mux_out = r_inputs[sel];

    always #5 clk = ~clk;

    mux_scan_sequencer #(.DWELL(DWELL), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
        .mux_out(w_mux_out), .frame_ready(frame_ready), .sel(sel),
        .frame(frame), .frame_valid(frame_valid), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [3:0] ins);
        r_inputs = ins;
        exp_q.push_back(ins);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(input int from, output int lat);
        lat = from;
        while (!frame_valid && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    // Scoreboard: each new frame_valid rise pops one expected frame.
    always @(negedge clk) begin
        if (!rst_n) begin
            seen_valid = 1'b0;
        end else begin
            if (frame_valid && !seen_valid) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got frame %0h expected no frame", frame);
                end else begin
                    check("sb_frame", frame, exp_q.pop_front());
                end
            end
            seen_valid = frame_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        int   lat;
        int   bad;
        vecs[0] = '{ins: 4'b1010, exp: 4'b1010};
        vecs[1] = '{ins: 4'b0000, exp: 4'b0000};
        vecs[2] = '{ins: 4'b1111, exp: 4'b1111};
        vecs[3] = '{ins: 4'b0101, exp: 4'b0101};
        vecs[4] = '{ins: 4'b1000, exp: 4'b1000};
        vecs[5] = '{ins: 4'b0011, exp: 4'b0011};

        // Reset and idle
        tick();
        tick();
        check("rst_sel", sel, 0);
        check("rst_frame", frame, 0);
        check("rst_valid", frame_valid, 0);
        check("rst_busy", busy, 0);
        @(negedge clk) rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (sel != 2'd0 || frame != 4'h0 || frame_valid || busy) bad++;
        end
        check("idle_hold", bad, 0);

        // Table-driven single scans, frame_ready held high
        for (int v = 0; v < 6; v++) begin
            launch(vecs[v].ins);
            lat = 0;
            bad = 0;
            while (!frame_valid && lat < 200) begin
                if (int'(sel) != lat / DWELL) bad++;
                tick();
                lat++;
            end
            check("sel_seq", bad, 0);
            check("latency", lat, LAT);
            check("frame", frame, vecs[v].exp);
            check("busy_done", busy, 1);
            tick();
            check("valid_1cycle", frame_valid, 0);
            check("idle_after", busy, 0);
        end

        // Back-pressure
        frame_ready = 1'b0;
        launch(4'b0110);
        wait_valid(0, lat);
        check("bp_latency", lat, LAT);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (frame != 4'b0110 || sel != 2'd3 || !busy || !frame_valid) bad++;
        end
        check("bp_stable", bad, 0);
        frame_ready = 1'b1;
        tick();
        check("bp_release_valid", frame_valid, 0);
        check("bp_release_busy", busy, 0);

        // Continuous: new inputs between scans, no idle bubble
        continuous = 1'b1;
        launch(4'b0001);
        wait_valid(0, lat);
        check("cont_latency", lat, LAT);
        r_inputs = 4'b1110;
        exp_q.push_back(4'b1110);
        tick();
        continuous = 1'b0;
        check("cont_restart_busy", busy, 1);
        check("cont_restart_sel", sel, 0);
        check("cont_restart_valid", frame_valid, 0);
        wait_valid(1, lat);
        check("cont_gap", lat, LAT + 1);
        check("cont_frame2", frame, 4'b1110);
        tick();
        check("cont_stop", busy, 0);

        // start re-pulsed mid-scan is ignored
        launch(4'b1100);
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid(3, lat);
        check("ign_latency", lat, LAT);
        // start coincident with the handshake has no effect
        start = 1'b1;
        tick();
        start = 1'b0;
        check("hs_start_ignored", busy, 0);
        tick();
        check("hs_start_idle", busy, 0);

        // Reset mid-scan at sel==2
        launch(4'b1011);
        bad = 0;
        while (sel != 2'd2 && bad < 50) begin
            tick();
            bad++;
        end
        check("mid_reached_sel2", sel, 2);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_sel", sel, 0);
        check("mid_rst_frame", frame, 0);
        check("mid_rst_valid", frame_valid, 0);
        check("mid_rst_busy", busy, 0);
        exp_q.delete();
        @(negedge clk) rst_n = 1'b1;
        tick();
        launch(4'b0111);
        wait_valid(0, lat);
        check("fresh_latency", lat, LAT);
        check("fresh_frame", frame, 4'b0111);
        tick();
        check("fresh_idle", busy, 0);

        tick();
        check("sb_drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
- Round-robin scan controller that sits directly upstream of the 4:1 bit multiplexer.
- Drives the mux select lines and dwells on each channel for a programmable settle time.
- Samples the mux output bit for each channel and assembles the four samples into a 4-bit frame.
- Presents the frame downstream with a valid/ready handshake; supports single-shot and continuous scanning.

Parameters:
- DWELL, default 2: cycles the select is held per channel before sampling; legal range 1..255.
- CNT_W, default 8: width of the dwell counter; must satisfy 2^CNT_W > DWELL.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request one scan; sampled only in IDLE.
- continuous  input  1  when high, a new scan starts immediately after each frame handshake.
- mux_out  input  1  output bit of the downstream-driven 4:1 mux.
- sel  output  2  registered select driven into the 4:1 mux.
- frame  output  4  assembled frame; bit i = sample taken with sel==i.
- frame_valid  output  1  frame is valid and held stable.
- frame_ready  input  1  consumer accepts the frame.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE, sel=0, cnt=0, shadow=0, frame=0, frame_valid=0, busy=0.
- States:
  - IDLE: sel=0. If start=1 at an edge: go to SCAN with sel=0, cnt=0.
  - SCAN: sel is held while cnt counts 0..DWELL-1.
    - At the edge where cnt==DWELL-1: shadow[sel] <= mux_out and cnt <= 0.
    - If sel<3: sel <= sel+1.
    - If sel==3: frame <= shadow with bit 3 = mux_out; frame_valid <= 1; go to DONE.
  - DONE: frame and frame_valid held stable until frame_ready=1 at an edge. On that handshake, frame_valid <= 0, then:
    - if continuous=1: go to SCAN with sel=0, cnt=0 (no idle bubble);
    - else: go to IDLE.
- Latency: frame_valid rises exactly 4*DWELL cycles after the edge that accepted start (8 cycles at DWELL=2).
- Channel timing: each channel gets exactly DWELL cycles of stable sel before its sample. The mux is combinational, so DWELL=1 is legal.
- frame updates only on scan completion. A partial scan never alters frame; shadow is internal.
- start is ignored while busy=1. A start pulse in the same cycle as the DONE handshake has no effect; continuous alone decides the restart.
- frame_ready while frame_valid=0 is ignored.
- continuous is sampled only at the DONE handshake edge. Changing it mid-scan does not alter the current scan.
- Back-pressure: in DONE with frame_ready=0 indefinitely, sel stays at 3, no further sampling occurs, and frame stays unchanged.
- Reset mid-scan or mid-DONE: all outputs return to reset values immediately, and the partial frame is discarded.

Optional Feature:
- Macro SCAN_MASK_EN.
- Defined: adds input ch_mask [3:0].
  - ch_mask is sampled when a scan starts (IDLE start, or continuous restart).
  - Masked-off channels (bit=0) are skipped with no dwell, and their frame bit reads 0.
  - sel advances to the next enabled channel in ascending order.
  - Latency becomes DWELL × (number of enabled channels).
  - If ch_mask==0 at scan start: go straight to DONE next edge with frame=0.
- Undefined: no ch_mask port; all four channels are always scanned.

Test Plan:
1. Reset then idle, DWELL=2: rst_n low mid-run -> sel=0, frame=0, frame_valid=0, busy=0 asynchronously; start=0 for 10 cycles -> no change.
2. Single scan, mux inputs 4'b1010, frame_ready=1, continuous=0: start pulse -> sel sequence 0,0,1,1,2,2,3,3; frame_valid high 8 cycles after start for 1 cycle; frame=4'b1010; back to IDLE.
3. Back-pressure: frame_ready=0 for 20 cycles after frame_valid -> frame stable at 4'b0110, sel=3, busy=1. Then frame_ready=1 -> valid drops next edge.
4. Continuous: continuous=1, frame_ready=1, inputs change 4'b0001 -> 4'b1110 between scans -> consecutive frames 4'b0001 then 4'b1110, with exactly 8 cycles between valid pulses.
5. Ignored start / mid-scan reset: start re-pulsed during SCAN -> no restart and latency unchanged. rst_n pulsed when sel=2 -> immediate reset values; a following start yields a full fresh frame.
6. SCAN_MASK_EN defined, ch_mask=4'b1001, inputs 4'b1111: sel visits 0 then 3; frame=4'b1001 after 4 cycles. ch_mask=0 -> frame=4'b0000 valid one edge after start.
